count_sequencer: RTL and testbench



---
 rtl/count_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_count_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// -----------------------------------------------------------------------------
// count_sequencer
//
// Purpose:
//   Sequences a CNT_W-bit down-counter through a list of up to NUM_SEG
//   programmable interval segments. The host loads segment lengths over a
//   valid/ready config port while idle, then pulses start. The block walks
//   the segments in index order. It emits a one-cycle seg_done pulse when a
//   segment's count reaches zero. It emits a one-cycle seq_done pulse when
//   the whole list has been walked.
//
// Parameters:
//   NUM_SEG  - number of segments (>=2)
//   CNT_W    - counter / segment-length width
//   PRESCALE - clk cycles per count tick (>=1)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   cfg_valid  in   config write request
//   cfg_ready  out  config write accept (high only while idle)
//   cfg_idx    in   segment index being written (out-of-range writes dropped)
//   cfg_len    in   segment length in ticks
//   start      in   begin sequence (honoured only while idle)
//   stop       in   abort sequence (returns to idle on the next edge)
//   busy       out  sequence in progress
//   seg_idx    out  active segment index
//   count      out  remaining ticks in the active segment
//   seg_done   out  1-cycle pulse when a non-empty segment reaches zero
//   seq_done   out  1-cycle pulse when the sequence completes
//
// Build option:
//   COUNT_SEQ_LOOP_EN - when defined, the sequence restarts from segment 0
//   after each seq_done and keeps looping until stop. If every length is
//   zero, the block still makes a single pass.
// -----------------------------------------------------------------------------
module count_sequencer #(
  parameter  int NUM_SEG  = 4,
  parameter  int CNT_W    = 4,
  parameter  int PRESCALE = 1,
  localparam int IDX_W    = $clog2(NUM_SEG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic [IDX_W-1:0] seg_idx,
  output logic [CNT_W-1:0] count,
  output logic             seg_done,
  output logic             seq_done
);

  // The prescaler needs at least one bit even when PRESCALE == 1.
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] seg_idx_q;
  logic [CNT_W-1:0] count_q;
  logic [PS_W-1:0]  ps_q;
  logic             seg_done_q;
  logic             seq_done_q;

  logic [CNT_W-1:0] len_q [NUM_SEG];

  logic             cfg_wr;
  logic [CNT_W-1:0] cur_len;
  logic             last_seg;
  logic             tick;
  logic             loop_again;
  logic [CNT_W-1:0] count_d;
  logic [IDX_W-1:0] seg_idx_inc_d;
  logic [PS_W-1:0]  ps_inc_d;

  // Config is accepted only while idle, so lengths never change under a run.
  assign cfg_ready = (state_q == IDLE);
  assign cfg_wr    = cfg_valid & cfg_ready;

  // Length register file. A write whose index matches no entry is silently
  // dropped, which covers out-of-range indices when NUM_SEG is not a power
  // of two.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SEG; gi++) begin : g_len
      always_ff @(posedge clk) begin
        if (rst) begin
          len_q[gi] <= '0;
        end else if (cfg_wr && (int'(cfg_idx) == gi)) begin
          len_q[gi] <= cfg_len;
        end
      end
    end
  endgenerate

`ifdef COUNT_SEQ_LOOP_EN
  // Loop only if at least one segment has work, to avoid an endless spin
  // through empty LOAD states.
  logic [NUM_SEG-1:0] len_nz;
  generate
    for (gi = 0; gi < NUM_SEG; gi++) begin : g_nz
      assign len_nz[gi] = |len_q[gi];
    end
  endgenerate
  assign loop_again = |len_nz;
`else
  assign loop_again = 1'b0;
`endif

  assign cur_len       = len_q[seg_idx_q];
  assign last_seg      = (seg_idx_q == IDX_W'(NUM_SEG - 1));
  assign tick          = (ps_q == PS_W'(PRESCALE - 1));
  assign count_d       = count_q - CNT_W'(1);
  assign seg_idx_inc_d = seg_idx_q + IDX_W'(1);
  assign ps_inc_d      = ps_q + PS_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      seg_idx_q  <= '0;
      count_q    <= '0;
      ps_q       <= '0;
      seg_done_q <= 1'b0;
      seq_done_q <= 1'b0;
    end else begin
      // Pulses default low; only the branches below raise them.
      seg_done_q <= 1'b0;
      seq_done_q <= 1'b0;

      if (stop && (state_q != IDLE)) begin
        // Abort wins over any pulse that would have been generated this edge.
        state_q   <= IDLE;
        seg_idx_q <= '0;
        count_q   <= '0;
        ps_q      <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !stop) begin
              state_q   <= LOAD;
              seg_idx_q <= '0;
            end
          end

          LOAD: begin
            count_q <= cur_len;
            ps_q    <= '0;
            if (cur_len != '0) begin
              state_q <= RUN;
            end else if (last_seg) begin
              // Empty final segment: finish without a seg_done pulse.
              state_q <= DONE;
            end else begin
              seg_idx_q <= seg_idx_inc_d;
              state_q   <= LOAD;
            end
          end

          RUN: begin
            if (tick) begin
              ps_q <= '0;
              // RUN is only entered with a non-zero count; <= 1 also keeps
              // the counter from ever wrapping below zero.
              if (count_q <= CNT_W'(1)) begin
                count_q    <= '0;
                seg_done_q <= 1'b1;
                if (last_seg) begin
                  state_q <= DONE;
                end else begin
                  seg_idx_q <= seg_idx_inc_d;
                  state_q   <= LOAD;
                end
              end else begin
                count_q <= count_d;
              end
            end else begin
              ps_q <= ps_inc_d;
            end
          end

          DONE: begin
            seq_done_q <= 1'b1;
            seg_idx_q  <= '0;
            count_q    <= '0;
            state_q    <= loop_again ? LOAD : IDLE;
          end

          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign busy     = (state_q != IDLE);
  assign seg_idx  = seg_idx_q;
  assign count    = count_q;
  assign seg_done = seg_done_q;
  assign seq_done = seq_done_q;

endmodule

// File: tb/tb_count_sequencer.sv
module tb_count_sequencer;

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic [1:0] cfg_idx;
  logic [3:0] cfg_len;
  logic       start;
  logic       stop;

  logic       cfg_ready, busy, seg_done, seq_done;
  logic [1:0] seg_idx;
  logic [3:0] count;

  logic       cfg_ready4, busy4, seg_done4, seq_done4;
  logic [1:0] seg_idx4;
  logic [3:0] count4;

  int checks;
  int errors;

  count_sequencer #(.NUM_SEG(4), .CNT_W(4), .PRESCALE(1)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idx(cfg_idx), .cfg_len(cfg_len),
    .start(start), .stop(stop),
    .busy(busy), .seg_idx(seg_idx), .count(count),
    .seg_done(seg_done), .seq_done(seq_done)
  );

  count_sequencer #(.NUM_SEG(4), .CNT_W(4), .PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready4),
    .cfg_idx(cfg_idx), .cfg_len(cfg_len),
    .start(start), .stop(stop),
    .busy(busy4), .seg_idx(seg_idx4), .count(count4),
    .seg_done(seg_done4), .seq_done(seq_done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] idx;
    logic [3:0] len;
    logic       st;
    logic       sp;
    logic       busy;
    logic [1:0] sidx;
    logic [3:0] cnt;
    logic       sd;
    logic       qd;
    logic       rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [1:0] idx, logic [3:0] len,
                              logic st, logic sp, logic b, logic [1:0] sidx,
                              logic [3:0] cnt, logic sd, logic qd, logic rdy);
    vec_t r;
    r.v = v; r.idx = idx; r.len = len; r.st = st; r.sp = sp;
    r.busy = b; r.sidx = sidx; r.cnt = cnt; r.sd = sd; r.qd = qd; r.rdy = rdy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] idx, input logic [3:0] len,
                       input logic st, input logic sp);
    cfg_valid = v; cfg_idx = idx; cfg_len = len; start = st; stop = sp;
  endtask

  // Expected dut4 (PRESCALE=4) outputs e edges after the start edge, with
  // lengths {2,2,0,0}.
  task automatic p4_expect(input int e, output logic b, output logic [1:0] sidx,
                           output logic [3:0] cnt, output logic sd, output logic qd);
    int f;
    b = 1'b1; sd = 1'b0; qd = 1'b0; sidx = 2'd0; cnt = 4'd0;
    if (e <= 9) begin
      sidx = (e == 9) ? 2'd1 : 2'd0;
      cnt  = (e <= 4) ? 4'd2 : (e <= 8) ? 4'd1 : 4'd0;
      sd   = (e == 9);
    end else if (e <= 18) begin
      f    = e - 9;
      sidx = (e == 18) ? 2'd2 : 2'd1;
      cnt  = (f <= 4) ? 4'd2 : (f <= 8) ? 4'd1 : 4'd0;
      sd   = (e == 18);
    end else if (e <= 20) begin
      sidx = 2'd3;
    end else begin
      b  = 1'b0;
      qd = 1'b1;
    end
  endtask

  initial begin
    logic       eb, esd, eqd;
    logic [1:0] esidx;
    logic [3:0] ecnt;

    checks = 0;
    errors = 0;
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;

    // ---------------- reset ----------------
    cyc();
    cyc();
    chk("rst.busy", busy, 0);
    chk("rst.count", count, 0);
    chk("rst.seg_idx", seg_idx, 0);
    chk("rst.seg_done", seg_done, 0);
    chk("rst.seq_done", seq_done, 0);
    chk("rst.busy4", busy4, 0);
    rst = 1'b0;
    cyc();
    chk("post_rst.cfg_ready", cfg_ready, 1);
    chk("post_rst.busy", busy, 0);

    // ---------------- table ----------------
    // All lengths zero after reset: four LOADs, DONE, seq_done, no seg_done.
    vecs.push_back(mk(0,0,0,1,0, 1,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,2,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,3,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,3,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,1,1));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0,1));
    // start together with stop while idle: stays idle
    vecs.push_back(mk(0,0,0,1,1, 0,0,0,0,0,1));
    // config writes len = {3,1,0,2} (len[2] overwritten 5 -> 0)
    vecs.push_back(mk(1,0,3,0,0, 0,0,0,0,0,1));
    vecs.push_back(mk(1,1,1,0,0, 0,0,0,0,0,1));
    vecs.push_back(mk(1,2,5,0,0, 0,0,0,0,0,1));
    vecs.push_back(mk(1,2,0,0,0, 0,0,0,0,0,1));
    vecs.push_back(mk(1,3,2,0,0, 0,0,0,0,0,1));
    // full run; a write and a start while busy are both ignored
    vecs.push_back(mk(0,0,0,1,0, 1,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,0,3,0,0,0));
    vecs.push_back(mk(1,0,7,0,0, 1,0,2,0,0,0));
    vecs.push_back(mk(0,0,0,1,0, 1,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,1,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,1,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,2,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,3,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,3,2,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,3,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,3,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,1,1));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0,1));
    // run 2: stop in RUN of seg 1 with count 1 -> idle, no seg_done
    vecs.push_back(mk(0,0,0,1,0, 1,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,0,3,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,0,2,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,1,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,1,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,1, 0,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0,1));
    // run 3: lengths intact after stop; stop during DONE suppresses seq_done
    vecs.push_back(mk(0,0,0,1,0, 1,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,0,3,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,0,2,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,1,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,1,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,2,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,3,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,3,2,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,3,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,3,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,1, 0,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0,1));
    // run 4: stop during LOAD
    vecs.push_back(mk(0,0,0,1,0, 1,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1, 0,0,0,0,0,1));

    foreach (vecs[k]) begin
      drive(vecs[k].v, vecs[k].idx, vecs[k].len, vecs[k].st, vecs[k].sp);
      cyc();
      $display("row %0d: v=%0d st=%0d sp=%0d -> busy=%0d idx=%0d cnt=%0d sd=%0d qd=%0d rdy=%0d",
               k, vecs[k].v, vecs[k].st, vecs[k].sp, busy, seg_idx, count, seg_done, seq_done, cfg_ready);
      chk($sformatf("row%0d.busy", k), busy, vecs[k].busy);
      chk($sformatf("row%0d.seg_idx", k), seg_idx, vecs[k].sidx);
      chk($sformatf("row%0d.count", k), count, vecs[k].cnt);
      chk($sformatf("row%0d.seg_done", k), seg_done, vecs[k].sd);
      chk($sformatf("row%0d.seq_done", k), seq_done, vecs[k].qd);
      chk($sformatf("row%0d.cfg_ready", k), cfg_ready, vecs[k].rdy);
    end
    drive(0, 0, 0, 0, 0);

    // ---------------- PRESCALE = 4, len = {2,2,0,0} ----------------
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'(i), (i < 2) ? 4'd2 : 4'd0, 0, 0);
      cyc();
    end
    drive(0, 0, 0, 1, 0);
    cyc();
    chk("p4.e0.busy", busy4, 1);
    chk("p4.e0.count", count4, 0);
    drive(0, 0, 0, 0, 0);
    for (int e = 1; e <= 22; e++) begin
      cyc();
      if (e == 22) begin
        chk("p4.e22.seq_done", seq_done4, 0);
        chk("p4.e22.cfg_ready", cfg_ready4, 1);
      end else begin
        p4_expect(e, eb, esidx, ecnt, esd, eqd);
        $display("p4 edge %0d: busy=%0d idx=%0d cnt=%0d sd=%0d qd=%0d",
                 e, busy4, seg_idx4, count4, seg_done4, seq_done4);
        chk($sformatf("p4.e%0d.busy", e), busy4, eb);
        chk($sformatf("p4.e%0d.seg_idx", e), seg_idx4, esidx);
        chk($sformatf("p4.e%0d.count", e), count4, ecnt);
        chk($sformatf("p4.e%0d.seg_done", e), seg_done4, esd);
        chk($sformatf("p4.e%0d.seq_done", e), seq_done4, eqd);
      end
    end

`ifdef COUNT_SEQ_LOOP_EN
    // ---------------- looping, len = {1,1,1,1}, PRESCALE = 1 ----------------
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'(i), 4'd1, 0, 0);
      cyc();
    end
    drive(0, 0, 0, 1, 0);
    cyc();
    drive(0, 0, 0, 0, 0);
    for (int e = 1; e <= 11; e++) begin
      cyc();
      $display("loop edge %0d: busy=%0d idx=%0d sd=%0d qd=%0d", e, busy, seg_idx, seg_done, seq_done);
      chk($sformatf("loop.e%0d.busy", e), busy, 1);
      chk($sformatf("loop.e%0d.seg_done", e), seg_done,
          ((e % 2 == 0) && (e <= 8)) || (e == 11));
      chk($sformatf("loop.e%0d.seq_done", e), seq_done, (e == 9));
    end
    drive(0, 0, 0, 0, 1);
    cyc();
    drive(0, 0, 0, 0, 0);
    chk("loop.stop.busy", busy, 0);
    chk("loop.stop.count", count, 0);
    chk("loop.stop.seg_idx", seg_idx, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
